// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler
//  Tear-free register scheduler between an Avalon-MM CPU slave and the sprite
//  compositor. CPU writes land in a shadow bank; the shadow bank is copied to
//  the active bank in a single cycle right after vertical blank starts.
//  The block also counts frames and steps the sprite animation phase.
//  Optional macro: SPRITE_SCHED_IRQ_EN adds an irq output raised on each commit.
module sprite_frame_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W     = 10,
  parameter int VACTIVE     = 480,
  parameter int ANIM_DIV    = 6,
  parameter int ANIM_PHASES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           chipselect,
  input  logic                           write,
  input  logic                           read,
  input  logic [8:0]                     address,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  input  logic [9:0]                     vcount,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  output logic [NUM_SPRITES-1:0]         spr_en,
  output logic [15:0]                    score,
  output logic [1:0]                     anim_phase,
  output logic [15:0]                    frame_count,
`ifdef SPRITE_SCHED_IRQ_EN
  output logic                           irq,
`endif
  output logic                           commit_pulse
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  localparam logic [8:0] A_EN     = 9'h20;
  localparam logic [8:0] A_SCORE  = 9'h21;
  localparam logic [8:0] A_CTRL   = 9'h22;
  localparam logic [8:0] A_STATUS = 9'h23;

  typedef logic [NUM_SPRITES-1:0][COORD_W-1:0] coord_arr_t;

  coord_arr_t             x_sh_q, x_sh_d, y_sh_q, y_sh_d;
  coord_arr_t             x_act_q, x_act_d, y_act_q, y_act_d;
  logic [NUM_SPRITES-1:0] en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic [15:0]            score_sh_q, score_sh_d, score_act_q, score_act_d;
  logic                   auto_q, auto_d, freeze_q, freeze_d;
  logic [1:0]             state_q, state_d;
  logic [9:0]             vcount_q, vcount_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             phase_q, phase_d;
  logic [31:0]            readdata_q, readdata_d, rd_val;
  logic                   commit_pulse_q, commit_pulse_d;
  logic                   commit_req, sh_wr, req, vblank_start, load, pending;
  logic                   irq_flag;
  logic                   unused_wd;

  assign unused_wd    = ^writedata[31:16];
  assign vblank_start = (vcount == 10'(VACTIVE)) && (vcount_q != 10'(VACTIVE));
  assign vcount_d     = vcount;
  assign pending      = (state_q != S_IDLE);
  // A commit request is an explicit COMMIT write or any shadow write under AUTO.
  assign req          = commit_req || (sh_wr && auto_q);
  assign load         = (state_q == S_PENDING) && vblank_start;

  // CPU write decode into the shadow bank and CTRL bits.
  always_comb begin
    x_sh_d     = x_sh_q;
    y_sh_d     = y_sh_q;
    en_sh_d    = en_sh_q;
    score_sh_d = score_sh_q;
    auto_d     = auto_q;
    freeze_d   = freeze_q;
    commit_req = 1'b0;
    sh_wr      = 1'b0;
    if (chipselect && write) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (address == 9'(2*i)) begin
          x_sh_d[i] = writedata[COORD_W-1:0];
          sh_wr     = 1'b1;
        end
        if (address == 9'(2*i+1)) begin
          y_sh_d[i] = writedata[COORD_W-1:0];
          sh_wr     = 1'b1;
        end
      end
      case (address)
        A_EN: begin
          en_sh_d = writedata[NUM_SPRITES-1:0];
          sh_wr   = 1'b1;
        end
        A_SCORE: begin
          score_sh_d = writedata[15:0];
          sh_wr      = 1'b1;
        end
        A_CTRL: begin
          commit_req = writedata[0];
          auto_d     = writedata[1];
          freeze_d   = writedata[2];
        end
        default: ;
      endcase
    end
  end

  // Commit FSM: a request arriving in the COMMIT cycle re-arms straight to PENDING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req) state_d = S_PENDING;
      S_PENDING: if (vblank_start) state_d = S_COMMIT;
      S_COMMIT:  state_d = req ? S_PENDING : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Active bank loads on the PENDING->COMMIT edge so it is visible in the COMMIT cycle;
  // a shadow write during COMMIT therefore waits for the next commit.
  always_comb begin
    x_act_d        = load ? x_sh_q     : x_act_q;
    y_act_d        = load ? y_sh_q     : y_act_q;
    en_act_d       = load ? en_sh_q    : en_act_q;
    score_act_d    = load ? score_sh_q : score_act_q;
    commit_pulse_d = load;
  end

  // Frame counter and animation divider, stepped once per vblank start.
  always_comb begin
    frame_count_d = frame_count_q;
    div_d         = div_q;
    phase_d       = phase_q;
    if (vblank_start) begin
      frame_count_d = frame_count_q + 16'd1;
      if (!freeze_q) begin
        if (div_q == DIV_W'(ANIM_DIV-1)) begin
          div_d   = '0;
          phase_d = (phase_q == 2'(ANIM_PHASES-1)) ? 2'd0 : phase_q + 2'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  // Read mux over the shadow bank and control/status; readdata holds between reads.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (address == 9'(2*i))   rd_val = 32'(x_sh_q[i]);
      if (address == 9'(2*i+1)) rd_val = 32'(y_sh_q[i]);
    end
    case (address)
      A_EN:     rd_val = 32'(en_sh_q);
      A_SCORE:  rd_val = 32'(score_sh_q);
      A_CTRL:   rd_val = {29'd0, freeze_q, auto_q, 1'b0};
      A_STATUS: rd_val = {frame_count_q, 13'd0, irq_flag, 1'b0, pending};
      default:  ;
    endcase
    readdata_d = (chipselect && read) ? rd_val : readdata_q;
  end

`ifdef SPRITE_SCHED_IRQ_EN
  logic irq_flag_q, irq_flag_d;

  // IRQ flag: set in the COMMIT cycle, cleared by writing STATUS bit 2; set wins.
  always_comb begin
    irq_flag_d = irq_flag_q;
    if (chipselect && write && (address == A_STATUS) && writedata[2]) irq_flag_d = 1'b0;
    if (state_q == S_COMMIT) irq_flag_d = 1'b1;
  end

  // IRQ flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_flag_q <= 1'b0;
    else       irq_flag_q <= irq_flag_d;
  end

  assign irq_flag = irq_flag_q;
  assign irq      = irq_flag_q;
`else
  assign irq_flag = 1'b0;
`endif

  // All architectural state; reset drops any pending commit immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sh_q         <= '0;
      y_sh_q         <= '0;
      en_sh_q        <= '0;
      score_sh_q     <= '0;
      x_act_q        <= '0;
      y_act_q        <= '0;
      en_act_q       <= '0;
      score_act_q    <= '0;
      auto_q         <= 1'b0;
      freeze_q       <= 1'b0;
      state_q        <= S_IDLE;
      vcount_q       <= '0;
      frame_count_q  <= '0;
      div_q          <= '0;
      phase_q        <= '0;
      readdata_q     <= '0;
      commit_pulse_q <= 1'b0;
    end else begin
      x_sh_q         <= x_sh_d;
      y_sh_q         <= y_sh_d;
      en_sh_q        <= en_sh_d;
      score_sh_q     <= score_sh_d;
      x_act_q        <= x_act_d;
      y_act_q        <= y_act_d;
      en_act_q       <= en_act_d;
      score_act_q    <= score_act_d;
      auto_q         <= auto_d;
      freeze_q       <= freeze_d;
      state_q        <= state_d;
      vcount_q       <= vcount_d;
      frame_count_q  <= frame_count_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      readdata_q     <= readdata_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  assign spr_x        = x_act_q;
  assign spr_y        = y_act_q;
  assign spr_en       = en_act_q;
  assign score        = score_act_q;
  assign anim_phase   = phase_q;
  assign frame_count  = frame_count_q;
  assign readdata     = readdata_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Self-checking bench for sprite_frame_scheduler: table-driven shadow readback
// plus directed sequences for commit timing, AUTO, animation, reset and STATUS.
module tb_sprite_frame_scheduler;
  localparam int NS = 8;
  localparam int CW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs, wr_en, rd_en;
  logic [8:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       readdata;
  logic [9:0]        vcount;
  logic [NS*CW-1:0]  spr_x, spr_y;
  logic [NS-1:0]     spr_en;
  logic [15:0]       score, frame_count;
  logic [1:0]        anim_phase;
  logic              commit_pulse;
`ifdef SPRITE_SCHED_IRQ_EN
  logic              irq;
`endif

  int checks   = 0;
  int failures = 0;

  sprite_frame_scheduler dut (
    .clk(clk), .reset(reset), .chipselect(cs), .write(wr_en), .read(rd_en),
    .address(addr), .writedata(wdata), .readdata(readdata), .vcount(vcount),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .score(score),
    .anim_phase(anim_phase), .frame_count(frame_count),
`ifdef SPRITE_SCHED_IRQ_EN
    .irq(irq),
`endif
    .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int i);
    return 32'(spr_x[i*CW +: CW]);
  endfunction

  function automatic logic [31:0] sy(input int i);
    return 32'(spr_y[i*CW +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d);
    cs = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [8:0] a, output logic [31:0] d);
    cs = 1'b1; rd_en = 1'b1; addr = a;
    tick();
    d = readdata;
    cs = 1'b0; rd_en = 1'b0;
  endtask

  // One short frame; returns in the cycle right after the vblank-start edge.
  task automatic frame();
    vcount = 10'd0;   tick();
    vcount = 10'd479; tick();
    vcount = 10'd480; tick();
  endtask

  task automatic do_reset();
    vcount = 10'd0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    tick();
  endtask

  vec_t        vecs[9];
  logic [31:0] d, d_last;

  initial begin
    vecs[0] = '{9'h000, 32'd100,       32'd100};
    vecs[1] = '{9'h001, 32'd50,        32'd50};
    vecs[2] = '{9'h003, 32'hFFFF_F12C, 32'h12C};
    vecs[3] = '{9'h00F, 32'h0000_03FF, 32'h3FF};
    vecs[4] = '{9'h020, 32'hFFFF_FFA5, 32'hA5};
    vecs[5] = '{9'h021, 32'h1234_BEEF, 32'hBEEF};
    vecs[6] = '{9'h030, 32'h0000_0005, 32'h0};
    vecs[7] = '{9'h01F, 32'h0000_0123, 32'h0};
    vecs[8] = '{9'h1FF, 32'hFFFF_FFFF, 32'h0};

    reset = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0; vcount = '0;
    repeat (2) tick();
    check("rst_spr_x", spr_x[31:0], 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_commit_pulse", 32'(commit_pulse), 32'h0);
    reset = 1'b0;
    tick();

    // Shadow writes and readback, no commit.
    for (int k = 0; k < 9; k++) begin
      cpu_wr(vecs[k].a, vecs[k].wd);
      cpu_rd(vecs[k].a, d);
      check($sformatf("rdback[%0d]", k), d, vecs[k].exp);
    end
    cpu_rd(9'h000, d_last);
    tick();
    check("rd_hold", readdata, d_last);
    frame(); frame();
    check("nocommit_spr_x0", sx(0), 32'h0);
    check("nocommit_en", 32'(spr_en), 32'h0);
    check("nocommit_frames", 32'(frame_count), 32'd2);
    cpu_rd(9'h023, d);
    check("nocommit_pending", d & 32'h1, 32'h0);

    // Explicit COMMIT mid-frame; active updates 1 cycle after vblank start.
    vcount = 10'd200; tick();
    cpu_wr(9'h022, 32'h1);
    cpu_rd(9'h022, d);
    check("ctrl_commit_reads0", d, 32'h0);
    cpu_rd(9'h023, d);
    check("commit_pending", d & 32'h1, 32'h1);
    vcount = 10'd479; tick();
    vcount = 10'd480;
    #1;
    check("pre_commit_x0", sx(0), 32'h0);
    check("pre_commit_pulse", 32'(commit_pulse), 32'h0);
    tick();
    check("commit_x0", sx(0), 32'd100);
    check("commit_pulse_hi", 32'(commit_pulse), 32'h1);
    check("commit_y1", sy(1), 32'h12C);
    check("commit_y7", sy(7), 32'h3FF);
    check("commit_en", 32'(spr_en), 32'hA5);
    check("commit_score", 32'(score), 32'hBEEF);
    tick();
    check("commit_pulse_lo", 32'(commit_pulse), 32'h0);
    cpu_rd(9'h023, d);
    check("post_commit_idle", d & 32'h1, 32'h0);

    // AUTO mode with a shadow write landing in the COMMIT cycle.
    cpu_wr(9'h022, 32'h2);
    cpu_wr(9'h003, 32'd20);
    frame();
    check("auto_commit_y1", sy(1), 32'd20);
    check("auto_commit_pulse", 32'(commit_pulse), 32'h1);
    cpu_wr(9'h003, 32'd300);
    check("commitcyc_wr_y1_held", sy(1), 32'd20);
    cpu_rd(9'h023, d);
    check("commitcyc_rearm", d & 32'h1, 32'h1);
    frame();
    check("auto_next_y1", sy(1), 32'd300);
    tick();
    cpu_wr(9'h022, 32'h0);

    // COMMIT request in the vblank-start cycle waits a full frame.
    vcount = 10'd0; tick();
    vcount = 10'd479;
    cpu_wr(9'h004, 32'd55);
    vcount = 10'd480;
    cpu_wr(9'h022, 32'h1);
    check("vbreq_no_pulse", 32'(commit_pulse), 32'h0);
    check("vbreq_x2_old", sx(2), 32'h0);
    cpu_rd(9'h023, d);
    check("vbreq_pending", d & 32'h1, 32'h1);
    frame();
    check("vbreq_x2_new", sx(2), 32'd55);
    tick();

    // STATUS irq flag.
`ifdef SPRITE_SCHED_IRQ_EN
    check("irq_set", 32'(irq), 32'h1);
    cpu_rd(9'h023, d);
    check("status_irq_set", (d >> 2) & 32'h1, 32'h1);
    cpu_wr(9'h023, 32'h4);
    check("irq_clear", 32'(irq), 32'h0);
`else
    cpu_rd(9'h023, d);
    check("status_irq_zero", (d >> 2) & 32'h1, 32'h0);
    cpu_wr(9'h023, 32'hFFFF_FFFF);
    cpu_rd(9'h023, d);
    check("status_wr_ignored", d & 32'h5, 32'h0);
`endif

    // Animation phase: steps every 6 frames over 3 phases, then freeze.
    do_reset();
    for (int f = 1; f <= 18; f++) begin
      frame();
      check($sformatf("phase_f%0d", f), 32'(anim_phase), 32'((f / 6) % 3));
    end
    check("frames_18", 32'(frame_count), 32'd18);
    cpu_wr(9'h022, 32'h4);
    repeat (12) frame();
    check("freeze_phase", 32'(anim_phase), 32'h0);
    check("frames_30", 32'(frame_count), 32'd30);
    cpu_rd(9'h023, d);
    check("status_fcount", d >> 16, 32'd30);
    cpu_wr(9'h022, 32'h0);
    repeat (5) frame();
    check("unfreeze_phase_5", 32'(anim_phase), 32'h0);
    frame();
    check("unfreeze_phase_6", 32'(anim_phase), 32'h1);

    // Reset while PENDING drops everything, including the pending commit.
    cpu_wr(9'h000, 32'd77);
    cpu_wr(9'h022, 32'h1);
    frame();
    check("pre_rst_x0", sx(0), 32'd77);
    tick();
    cpu_wr(9'h001, 32'd88);
    cpu_wr(9'h022, 32'h1);
    #2;
    vcount = 10'd0;
    reset  = 1'b1;
    #1;
    check("async_rst_x0", sx(0), 32'h0);
    check("async_rst_phase", 32'(anim_phase), 32'h0);
    check("async_rst_fcount", 32'(frame_count), 32'h0);
    #1;
    reset = 1'b0;
    tick();
    cpu_rd(9'h023, d);
    check("rst_idle", d & 32'h1, 32'h0);
    cpu_rd(9'h001, d);
    check("rst_shadow_y0", d, 32'h0);
    frame();
    check("rst_no_pulse", 32'(commit_pulse), 32'h0);
    check("rst_no_commit_y0", sy(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
